// File: rtl/pipe_reg_chain_if.sv
// Upstream handshake, per-stage hazard controls and status outputs of pipe_reg_chain.
interface pipe_reg_chain_if #(
    parameter int DATA_W = 32,
    parameter int STAGES = 4,
    parameter int CNT_W  = 16
);
    localparam int OCC_W = $clog2(STAGES + 1);

    logic                       in_valid;
    logic [DATA_W-1:0]          in_data;
    logic                       in_ready;
    logic [STAGES-1:0]          freeze;
    logic [STAGES-1:0]          flush;
    logic [STAGES-1:0]          stage_valid;
    logic [STAGES*DATA_W-1:0]   stage_data;
    logic                       out_valid;
    logic [DATA_W-1:0]          out_data;
    logic [OCC_W-1:0]           occupancy;
    logic [CNT_W-1:0]           stall_cnt;
    logic [CNT_W-1:0]           flush_cnt;

    modport master (
        output in_valid, in_data, freeze, flush,
        input  in_ready, stage_valid, stage_data, out_valid, out_data,
               occupancy, stall_cnt, flush_cnt
    );

    modport slave (
        input  in_valid, in_data, freeze, flush,
        output in_ready, stage_valid, stage_data, out_valid, out_data,
               occupancy, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_reg_chain.sv
// Parametrised pipeline register chain with freeze/flush, bubble insertion,
// occupancy reporting and saturating stall/flush statistics.
module pipe_reg_chain #(
    parameter int                DATA_W     = 32,
    parameter int                STAGES     = 4,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int                CNT_W      = 16
) (
    input  logic            clk,
    input  logic            rst,
    pipe_reg_chain_if.slave bus
);
    localparam int               OCC_W   = $clog2(STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [STAGES-1:0]             hold;
    logic [STAGES-1:0]             kill;
    logic [STAGES-1:0]             srcValid;
    logic [STAGES-1:0]             srcBubble;
    logic [STAGES-1:0][DATA_W-1:0] srcData;
    logic                          anyFreeze;
    logic                          anyFlush;

    logic [STAGES-1:0]             valid_q, valid_d;
    logic [STAGES-1:0][DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]              stallCnt_q, stallCnt_d;
    logic [CNT_W-1:0]              flushCnt_q, flushCnt_d;
    logic [OCC_W-1:0]              occupancy;

    // A freeze or flush at any register also governs every register upstream of it.
    always_comb begin
        hold = '0;
        kill = '0;
        for (int i = 0; i < STAGES; i++) begin
            hold[i] = |(bus.freeze >> i);
            kill[i] = |(bus.flush >> i);
        end
    end

    assign anyFreeze = |bus.freeze;
    assign anyFlush  = |bus.flush;

    assign srcValid  = {valid_q[STAGES-2:0], bus.in_valid};
    assign srcData   = {data_q[STAGES-2:0], bus.in_data};
    assign srcBubble = {hold[STAGES-2:0], 1'b0};

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        for (int i = 0; i < STAGES; i++) begin
            if (kill[i] || (!hold[i] && srcBubble[i])) begin
                valid_d[i] = 1'b0;
                data_d[i]  = BUBBLE_VAL;
            end else if (!hold[i]) begin
                valid_d[i] = srcValid[i];
                data_d[i]  = srcData[i];
            end
        end
    end

    always_comb begin
        stallCnt_d = stallCnt_q;
        flushCnt_d = flushCnt_q;
        if (anyFreeze && (stallCnt_q != CNT_MAX)) stallCnt_d = stallCnt_q + CNT_W'(1);
        if (anyFlush  && (flushCnt_q != CNT_MAX)) flushCnt_d = flushCnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= '0;
            data_q     <= {STAGES{BUBBLE_VAL}};
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            data_q     <= data_d;
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) begin
            occupancy = occupancy + OCC_W'(valid_q[i]);
        end
    end

    // An entry offered during a flush is reported consumed and dropped (wrong-path kill).
    assign bus.in_ready    = !hold[0] || anyFlush;
    assign bus.stage_valid = valid_q;
    assign bus.stage_data  = data_q;
    assign bus.out_valid   = valid_q[STAGES-1];
    assign bus.out_data    = data_q[STAGES-1];
    assign bus.occupancy   = occupancy;
    assign bus.stall_cnt   = stallCnt_q;
    assign bus.flush_cnt   = flushCnt_q;
endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: two instances (16-bit and 4-bit counters) share one stimulus
// and are compared every cycle against an index-based model of the chain.
module tb_pipe_reg_chain;
    localparam int                DATA_W  = 32;
    localparam int                STAGES  = 4;
    localparam logic [DATA_W-1:0] BUBBLE  = 32'hDEAD_BEEF;
    localparam int                CNT_W_A = 16;
    localparam int                CNT_W_B = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                inValid = 1'b0;
    logic [DATA_W-1:0]   inData  = '0;
    logic [STAGES-1:0]   freeze  = '0;
    logic [STAGES-1:0]   flush   = '0;

    int checks = 0;
    int errors = 0;

    bit                  mValid [STAGES];
    logic [DATA_W-1:0]   mData  [STAGES];
    int                  mStall = 0;
    int                  mFlush = 0;
    int                  mFz, mFl, mOcc;
    int                  relExp [4] = '{8, 9, 10, 14};

    pipe_reg_chain_if #(.DATA_W(DATA_W), .STAGES(STAGES), .CNT_W(CNT_W_A)) busA ();
    pipe_reg_chain_if #(.DATA_W(DATA_W), .STAGES(STAGES), .CNT_W(CNT_W_B)) busB ();

    assign busA.in_valid = inValid;
    assign busA.in_data  = inData;
    assign busA.freeze   = freeze;
    assign busA.flush    = flush;
    assign busB.in_valid = inValid;
    assign busB.in_data  = inData;
    assign busB.freeze   = freeze;
    assign busB.flush    = flush;

    pipe_reg_chain #(.DATA_W(DATA_W), .STAGES(STAGES), .BUBBLE_VAL(BUBBLE), .CNT_W(CNT_W_A))
        dutA (.clk(clk), .rst(rst), .bus(busA));
    pipe_reg_chain #(.DATA_W(DATA_W), .STAGES(STAGES), .BUBBLE_VAL(BUBBLE), .CNT_W(CNT_W_B))
        dutB (.clk(clk), .rst(rst), .bus(busB));

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d,
                                 input logic [STAGES-1:0] fz, input logic [STAGES-1:0] fl);
        inValid = v;
        inData  = d;
        freeze  = fz;
        flush   = fl;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] sat(input int cnt, input int w);
        int maxVal;
        maxVal = (1 << w) - 1;
        return 64'((cnt > maxVal) ? maxVal : cnt);
    endfunction

    function automatic logic [STAGES-1:0] randMask(input int oneIn);
        logic [STAGES-1:0] m;
        m = '0;
        for (int i = 0; i < STAGES; i++) m[i] = ($urandom_range(0, oneIn - 1) == 0);
        return m;
    endfunction

    // Model: everything up to the furthest flush is bubbled, everything up to the furthest
    // freeze holds, the slot just below the freeze gets a bubble, the rest shift by one.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) begin
                mValid[i] = 1'b0;
                mData[i]  = BUBBLE;
            end
            mStall = 0;
            mFlush = 0;
        end else begin
            mFz = -1;
            mFl = -1;
            for (int i = 0; i < STAGES; i++) begin
                if (freeze[i]) mFz = i;
                if (flush[i])  mFl = i;
            end
            for (int i = STAGES - 1; i >= 0; i--) begin
                if (i <= mFl || (mFz >= 0 && i == mFz + 1)) begin
                    mValid[i] = 1'b0;
                    mData[i]  = BUBBLE;
                end else if (i > mFz) begin
                    mValid[i] = (i == 0) ? inValid : mValid[i-1];
                    mData[i]  = (i == 0) ? inData  : mData[i-1];
                end
            end
            if (freeze != '0) mStall++;
            if (flush  != '0) mFlush++;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            mOcc = 0;
            for (int i = 0; i < STAGES; i++) begin
                mOcc += int'(mValid[i]);
                checkOutput($sformatf("stage_valid[%0d]", i), 64'(busA.stage_valid[i]), 64'(mValid[i]));
                checkOutput($sformatf("stage_data[%0d]", i), 64'(busA.stage_data[i*DATA_W +: DATA_W]), 64'(mData[i]));
            end
            checkOutput("out_valid", 64'(busA.out_valid), 64'(mValid[STAGES-1]));
            checkOutput("out_data", 64'(busA.out_data), 64'(mData[STAGES-1]));
            checkOutput("occupancy", 64'(busA.occupancy), 64'(mOcc));
            checkOutput("in_ready", 64'(busA.in_ready), 64'((freeze == '0) || (flush != '0)));
            checkOutput("stall_cnt_A", 64'(busA.stall_cnt), sat(mStall, CNT_W_A));
            checkOutput("flush_cnt_A", 64'(busA.flush_cnt), sat(mFlush, CNT_W_A));
            checkOutput("stall_cnt_B", 64'(busB.stall_cnt), sat(mStall, CNT_W_B));
            checkOutput("flush_cnt_B", 64'(busB.flush_cnt), sat(mFlush, CNT_W_B));
            checkOutput("out_data_B", 64'(busB.out_data), 64'(mData[STAGES-1]));
            checkOutput("stage_valid_B", 64'(busB.stage_valid), 64'(busA.stage_valid));
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        checkOutput("reset_stage_valid", 64'(busA.stage_valid), 64'(0));
        checkOutput("reset_out_data", 64'(busA.out_data), 64'(BUBBLE));
        checkOutput("reset_occupancy", 64'(busA.occupancy), 64'(0));
        checkOutput("reset_stall_cnt", 64'(busA.stall_cnt), 64'(0));
        #10 rst = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b1, DATA_W'(k), '0, '0);
            checkOutput("stream_out_valid", 64'(busA.out_valid), 64'(k >= 4));
            if (k >= 4) checkOutput("stream_out_data", 64'(busA.out_data), 64'(k - 3));
            if (k == 4) checkOutput("stream_occupancy", 64'(busA.occupancy), 64'(4));
        end
        checkOutput("stream_stall_cnt", 64'(busA.stall_cnt), 64'(0));
        checkOutput("stream_flush_cnt", 64'(busA.flush_cnt), 64'(0));

        for (int c = 0; c < 3; c++) begin
            inValid = 1'b1;
            inData  = DATA_W'(100 + c);
            freeze  = 4'b0100;
            flush   = '0;
            #1;
            checkOutput("freeze_in_ready", 64'(busA.in_ready), 64'(0));
            if (c == 0) checkOutput("freeze_emit_A", 64'(busA.out_data), 64'(7));
            @(posedge clk);
            #1;
            checkOutput("freeze_hold_r0", 64'(busA.stage_data[0*DATA_W +: DATA_W]), 64'(10));
            checkOutput("freeze_hold_r1", 64'(busA.stage_data[1*DATA_W +: DATA_W]), 64'(9));
            checkOutput("freeze_hold_r2", 64'(busA.stage_data[2*DATA_W +: DATA_W]), 64'(8));
            checkOutput("freeze_bubble_r3", 64'(busA.out_valid), 64'(0));
        end
        checkOutput("freeze_stall_cnt", 64'(busA.stall_cnt), 64'(3));
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, DATA_W'(14 + c), '0, '0);
            checkOutput("release_out_data", 64'(busA.out_data), 64'(relExp[c]));
        end

        inValid = 1'b1;
        inData  = DATA_W'(99);
        freeze  = '0;
        flush   = 4'b0010;
        #1;
        checkOutput("flush_in_ready", 64'(busA.in_ready), 64'(1));
        @(posedge clk);
        #1;
        checkOutput("flush_stage_valid", 64'(busA.stage_valid), 64'(4'b1100));
        checkOutput("flush_r0_bubble", 64'(busA.stage_data[0*DATA_W +: DATA_W]), 64'(BUBBLE));
        checkOutput("flush_r2", 64'(busA.stage_data[2*DATA_W +: DATA_W]), 64'(16));
        checkOutput("flush_r3", 64'(busA.stage_data[3*DATA_W +: DATA_W]), 64'(15));
        checkOutput("flush_occupancy", 64'(busA.occupancy), 64'(2));
        checkOutput("flush_flush_cnt", 64'(busA.flush_cnt), 64'(1));

        applyStimulus(1'b1, DATA_W'(20), '0, '0);
        applyStimulus(1'b1, DATA_W'(21), '0, '0);
        applyStimulus(1'b1, DATA_W'(22), 4'b0010, 4'b1000);
        checkOutput("both_stage_valid", 64'(busA.stage_valid), 64'(0));
        checkOutput("both_out_valid", 64'(busA.out_valid), 64'(0));
        checkOutput("both_occupancy", 64'(busA.occupancy), 64'(0));
        checkOutput("both_stall_cnt", 64'(busA.stall_cnt), 64'(4));
        checkOutput("both_flush_cnt", 64'(busA.flush_cnt), 64'(2));

        for (int c = 0; c < 400; c++) begin
            applyStimulus($urandom_range(0, 3) != 0, DATA_W'($urandom), randMask(6), randMask(14));
        end

        for (int c = 0; c < 3; c++) applyStimulus(1'b1, DATA_W'(200 + c), '0, '0);
        #3;
        rst     = 1'b0;
        inValid = 1'b0;
        #1;
        checkOutput("async_stage_valid", 64'(busA.stage_valid), 64'(0));
        checkOutput("async_out_data", 64'(busA.out_data), 64'(BUBBLE));
        checkOutput("async_stall_cnt_A", 64'(busA.stall_cnt), 64'(0));
        checkOutput("async_flush_cnt_A", 64'(busA.flush_cnt), 64'(0));
        checkOutput("async_stall_cnt_B", 64'(busB.stall_cnt), 64'(0));
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, DATA_W'(300 + k), '0, '0);
            checkOutput("restart_out_valid", 64'(busA.out_valid), 64'(k >= 4));
            if (k == 4) checkOutput("restart_first_out", 64'(busA.out_data), 64'(301));
        end

        for (int c = 1; c <= 20; c++) begin
            applyStimulus(1'b0, '0, 4'b0001, '0);
            checkOutput("sat_stall_cnt_B", 64'(busB.stall_cnt), 64'((c > 15) ? 15 : c));
            checkOutput("sat_stall_cnt_A", 64'(busA.stall_cnt), 64'(c));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
